// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: sign-magnitude operands, one shift-add or
// restoring-subtract step per cycle, then a single sign-fixup / result-select cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset_n,
    input  logic              MD_start,
    input  logic [2:0]        MD_funct3,
    input  logic [XLEN-1:0]   MD_rs1_data,
    input  logic [XLEN-1:0]   MD_rs2_data,
    input  logic              MD_flush,
    output logic              MD_busy,
    output logic              MD_done,
    output logic [XLEN-1:0]   MD_result
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]          state_q,   state_d;
    logic [CW-1:0]       counter_q, counter_d;
    logic [2:0]          funct3_q,  funct3_d;
    logic [XLEN-1:0]     a_q,       a_d;
    logic [XLEN-1:0]     mag_b_q,   mag_b_d;
    logic [2*XLEN-1:0]   acc_q,     acc_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic                special_q, special_d;
    logic [XLEN-1:0]     result_q,  result_d;

    // Operand decode on the request inputs
    logic                is_div_in;
    logic                signed_a_in;
    logic                signed_b_in;
    logic                a_neg_in;
    logic                b_neg_in;
    logic [XLEN-1:0]     mag_a_in;
    logic [XLEN-1:0]     mag_b_in;
    logic                div_zero_in;
    logic                ovf_in;
    logic                accept;

    always_comb begin
        is_div_in   = MD_funct3[2];
        signed_a_in = MD_funct3[2] ? ~MD_funct3[0] : (MD_funct3[1:0] != 2'b11);
        signed_b_in = MD_funct3[2] ? ~MD_funct3[0] : ~MD_funct3[1];
        a_neg_in    = signed_a_in & MD_rs1_data[XLEN-1];
        b_neg_in    = signed_b_in & MD_rs2_data[XLEN-1];
        // The most negative value maps onto its unsigned magnitude 2^(XLEN-1).
        mag_a_in    = a_neg_in ? (~MD_rs1_data + 1'b1) : MD_rs1_data;
        mag_b_in    = b_neg_in ? (~MD_rs2_data + 1'b1) : MD_rs2_data;
        div_zero_in = is_div_in && (MD_rs2_data == '0);
        ovf_in      = is_div_in && !MD_funct3[0]
                      && (MD_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                      && (MD_rs2_data == {XLEN{1'b1}});
        accept      = MD_start && !MD_flush && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Iteration datapath: acc holds {hi, lo} = {partial product, multiplier}
    // for multiplies and {partial remainder, dividend/quotient} for divides.
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift;
    logic [XLEN-1:0]     div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                    + (acc_q[0] ? {1'b0, mag_b_q} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, mag_b_q});
        div_diff  = div_shift[XLEN-1:0] - mag_b_q;
        div_next  = div_ge ? {div_diff,            acc_q[XLEN-2:0], 1'b1}
                           : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    // Final sign fix-up and result selection
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix;
    logic [XLEN-1:0]     rem_fix;
    logic [XLEN-1:0]     special_res;
    logic [XLEN-1:0]     fix_res;

    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

        // Zero divisor vs. signed overflow; funct3[1] separates rem from div.
        if (mag_b_q == '0) begin
            special_res = funct3_q[1] ? a_q : {XLEN{1'b1}};
        end else begin
            special_res = funct3_q[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end

        fix_res = '0;
        case (funct3_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
        if (special_q) begin
            fix_res = special_res;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        funct3_d  = funct3_q;
        a_d       = a_q;
        mag_b_d   = mag_b_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        special_d = special_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    funct3_d  = MD_funct3;
                    a_d       = MD_rs1_data;
                    mag_b_d   = mag_b_in;
                    acc_d     = {{XLEN{1'b0}}, mag_a_in};
                    neg_res_d = a_neg_in ^ b_neg_in;
                    neg_rem_d = a_neg_in;
                    special_d = div_zero_in | ovf_in;
                    counter_d = '0;
                    state_d   = (div_zero_in | ovf_in) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                acc_d     = funct3_q[2] ? div_next : mul_next;
                counter_d = counter_q + 1'b1;
                if (counter_q == CW'(XLEN-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (MD_flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            funct3_q  <= '0;
            a_q       <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            funct3_q  <= funct3_d;
            a_q       <= a_d;
            mag_b_q   <= mag_b_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            special_q <= special_d;
            result_q  <= result_d;
        end
    end

    assign MD_busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign MD_done   = (state_q == S_DONE);
    assign MD_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, multi-cycle corner sequences and a
// random run against a 64-bit behavioural model, all checked through a result scoreboard.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        md_start;
    logic [2:0]  md_funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        md_flush;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_result;

    muldiv_unit #(.XLEN(32)) dut (
        .SYS_clk     (clk),
        .SYS_reset_n (rst_n),
        .MD_start    (md_start),
        .MD_funct3   (md_funct3),
        .MD_rs1_data (rs1),
        .MD_rs2_data (rs2),
        .MD_flush    (md_flush),
        .MD_busy     (md_busy),
        .MD_done     (md_done),
        .MD_result   (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        string       name;
    } exp_t;

    int   vectors     = 0;
    int   miscompares = 0;
    int   dones_seen  = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // RISC-V M semantics computed with 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f3)
            3'd0: begin p = sa * sb;           return p[31:0];  end
            3'd1: begin p = sa * sb;           return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;           return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return 34;
    endfunction

    // Scoreboard consumer: every MD_done pops one expected result
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && md_done) begin
            dones_seen++;
            if (exp_q.size() == 0) begin
                chk("spurious_done", {31'b0, md_done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk(e.name, md_result, e.res);
            end
        end
    end

    // Issue one op (start high for exactly one cycle) and check its latency
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        int c;
        @(negedge clk);
        md_funct3 = f3;
        rs1       = a;
        rs2       = b;
        md_start  = 1'b1;
        exp_q.push_back('{exp, name});
        c = 0;
        do begin
            @(negedge clk);
            md_start = 1'b0;
            c++;
        end while (!md_done && c < 100);
        chk({name, "_latency"}, 32'(c), 32'(exp_latency(f3, a, b)));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int          c;
        int          d0;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int          pick;

        rst_n     = 1'b0;
        md_start  = 1'b0;
        md_flush  = 1'b0;
        md_funct3 = 3'd0;
        rs1       = 32'd0;
        rs2       = 32'd0;

        tbl.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3"});
        tbl.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh_min_min"});
        tbl.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"});
        tbl.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_max"});
        tbl.push_back('{3'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "mul_min_m1"});
        tbl.push_back('{3'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, "mulh_min_m1"});
        tbl.push_back('{3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "mulhsu_min_max"});
        tbl.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2"});
        tbl.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2"});
        tbl.push_back('{3'd4, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFE, "div_7_m3"});
        tbl.push_back('{3'd6, 32'd7,          32'hFFFF_FFFD, 32'd1,         "rem_7_m3"});
        tbl.push_back('{3'd5, 32'd100,        32'd7,         32'd14,        "divu_100_7"});
        tbl.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         "remu_100_7"});
        tbl.push_back('{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, "div_5_0"});
        tbl.push_back('{3'd6, 32'd5,          32'd0,         32'd5,         "rem_5_0"});
        tbl.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, "divu_5_0"});
        tbl.push_back('{3'd7, 32'd5,          32'd0,         32'd5,         "remu_5_0"});
        tbl.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"});
        tbl.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf"});

        // Reset state
        idle_cycles(3);
        chk("reset_busy",   {31'b0, md_busy}, 32'd0);
        chk("reset_done",   {31'b0, md_done}, 32'd0);
        chk("reset_result", md_result,        32'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        foreach (tbl[i]) do_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].name);

        // A second start while busy is ignored
        @(negedge clk);
        md_funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; md_start = 1'b1;
        exp_q.push_back('{32'd14, "busy_first"});
        d0 = dones_seen;
        c  = 0;
        do begin
            @(negedge clk);
            c++;
            md_start = (c == 10);
            if (c == 10) begin
                md_funct3 = 3'd0; rs1 = 32'd1; rs2 = 32'd1;
            end
        end while (!md_done && c < 100);
        chk("busy_first_latency", 32'(c), 32'd34);
        idle_cycles(40);
        chk("busy_second_ignored", 32'(dones_seen - d0), 32'd1);

        // Start held through DONE: the next op is accepted back-to-back
        @(negedge clk);
        md_funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4; md_start = 1'b1;
        exp_q.push_back('{32'd12, "hold_first"});
        c = 0;
        do begin @(negedge clk); c++; end while (!md_done && c < 100);
        chk("hold_first_latency", 32'(c), 32'd34);
        md_funct3 = 3'd4; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2;
        exp_q.push_back('{32'hFFFF_FFFD, "hold_second"});
        c = 0;
        do begin @(negedge clk); md_start = 1'b0; c++; end while (!md_done && c < 100);
        chk("hold_second_latency", 32'(c), 32'd34);

        // Flush mid-divide: no done, busy drops next cycle, result keeps 0xFFFFFFFD
        @(negedge clk);
        md_funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; md_start = 1'b1;
        d0 = dones_seen;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            md_start = 1'b0;
        end
        chk("flush_busy_before", {31'b0, md_busy}, 32'd1);
        md_flush = 1'b1;
        @(negedge clk);
        md_flush = 1'b0;
        chk("flush_busy_after", {31'b0, md_busy}, 32'd0);
        idle_cycles(40);
        chk("flush_no_done", 32'(dones_seen - d0), 32'd0);
        chk("flush_result_kept", md_result, 32'hFFFF_FFFD);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        md_funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; md_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            md_start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("areset_busy",   {31'b0, md_busy}, 32'd0);
        chk("areset_done",   {31'b0, md_done}, 32'd0);
        chk("areset_result", md_result,        32'd0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(1);
        do_op(3'd0, 32'd3, 32'd4, 32'd12, "post_reset_mul");

        // Random regression against the behavioural model
        for (int i = 0; i < 150; i++) begin
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            pick = $urandom_range(0, 9);
            if (pick == 0) b = 32'd0;
            if (pick == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (pick == 2) b = 32'($urandom_range(1, 15));
            if (pick == 3) a = 32'h8000_0000;
            do_op(f3, a, b, model(f3, a, b), $sformatf("rand%0d_f%0d", i, f3));
        end

        idle_cycles(3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
